// File: rtl/layer_sequencer.sv
// Per-layer one-hot enable sequencer with programmable per-layer cycle counts.
// Optional LAYER_ACK_EN macro adds a WAIT_ACK state gated by layer_ack.
module layer_sequencer #(
    parameter int LAYER_NO = 4,
    parameter int CNT_W    = 8,
    parameter int PASS_W   = 8,
    parameter int IDX_W    = (LAYER_NO > 1) ? $clog2(LAYER_NO) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      loop_en,
    input  logic                      hold,
    input  logic                      abort,
    input  logic [LAYER_NO*CNT_W-1:0] layer_cycles,
    input  logic [LAYER_NO-1:0]       layer_ack,
    output logic [LAYER_NO-1:0]       layer_en,
    output logic [IDX_W-1:0]          layer_idx,
    output logic                      busy,
    output logic                      done,
    output logic [PASS_W-1:0]         pass_cnt
);

`ifdef LAYER_ACK_EN
    typedef enum logic [1:0] {IDLE, RUN, WAIT_ACK} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
    logic unused_ack;
    assign unused_ack = ^layer_ack;
`endif

    state_t                    state, state_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [PASS_W-1:0]         pass, pass_n;
    logic                      done_n;
    logic                      latch;
    logic [LAYER_NO*CNT_W-1:0] lens;
    logic [CNT_W-1:0]          len_raw, len_eff;
    logic                      last;

    // A programmed length of 0 still gives the layer one active cycle
    assign len_raw = lens[idx*CNT_W +: CNT_W];
    assign len_eff = (len_raw == '0) ? CNT_W'(1) : len_raw;
    assign last    = (cnt == len_eff - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            pass  <= '0;
            done  <= 1'b0;
            lens  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            pass  <= pass_n;
            done  <= done_n;
            if (latch) lens <= layer_cycles;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        pass_n  = pass;
        done_n  = 1'b0;
        latch   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    idx_n   = '0;
                    cnt_n   = '0;
                    pass_n  = '0;
                    latch   = 1'b1;
                end
            end
            default: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (!hold) begin
                    if (state == RUN) begin
                        cnt_n = cnt + 1'b1;
                    end
                    if ((state == RUN) && last) begin
                        cnt_n = '0;
                    end
`ifdef LAYER_ACK_EN
                    if ((state == RUN) && last) begin
                        state_n = WAIT_ACK;
                    end
                    if ((state == WAIT_ACK) && layer_ack[idx]) begin
`else
                    if ((state == RUN) && last) begin
`endif
                        state_n = RUN;
                        if (idx == IDX_W'(LAYER_NO - 1)) begin
                            pass_n = pass + 1'b1;
                            idx_n  = '0;
                            if (!loop_en) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        layer_en      = '0;
        layer_en[idx] = (state != IDLE);
    end

    assign busy      = (state != IDLE);
    assign layer_idx = idx;
    assign pass_cnt  = pass;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer (4 layers, 8-bit counts).
// Define LAYER_ACK_EN for both bench and RTL to exercise the ack handshake.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        loop_en;
    logic        hold;
    logic        abort;
    logic [31:0] layer_cycles;
    logic [3:0]  layer_ack;
    logic [3:0]  layer_en;
    logic [1:0]  layer_idx;
    logic        busy;
    logic        done;
    logic [7:0]  pass_cnt;

    int n_cmp = 0;
    int n_err = 0;

    layer_sequencer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .loop_en(loop_en),
        .hold(hold),
        .abort(abort),
        .layer_cycles(layer_cycles),
        .layer_ack(layer_ack),
        .layer_en(layer_en),
        .layer_idx(layer_idx),
        .busy(busy),
        .done(done),
        .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nibble i of s is the expected layer_en in the i-th checked cycle
    task automatic seq(input string tag, input int n, input logic [127:0] s);
        for (int i = 0; i < n; i++) begin
            chk(tag, {28'd0, layer_en}, {28'd0, s[4*i +: 4]});
            chk({tag, "_busy"}, {31'd0, busy}, {31'd0, s[4*i +: 4] != 4'd0});
            chk({tag, "_done"}, {31'd0, done}, 32'd0);
            cyc();
        end
    endtask

    task automatic end_chk(input string tag, input logic [7:0] p);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_en"}, {28'd0, layer_en}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pass"}, {24'd0, pass_cnt}, {24'd0, p});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; loop_en = 1'b0; hold = 1'b0;
        abort = 1'b0; layer_cycles = 32'h0; layer_ack = 4'h0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset and idle
        for (int i = 0; i < 5; i++) begin
            chk("rst_en", {28'd0, layer_en}, 32'd0);
            chk("rst_idx", {30'd0, layer_idx}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_pass", {24'd0, pass_cnt}, 32'd0);
            cyc();
        end

`ifndef LAYER_ACK_EN
        // Single run L0=3 L1=1 L2=4 L3=2
        layer_cycles = 32'h02040103;
        start = 1'b1; cyc(); start = 1'b0;
        seq("run1", 10, 128'h8844442111);
        end_chk("run1_end", 8'd1);
        cyc();
        chk("run1_pulse", {31'd0, done}, 32'd0);

        // L1=0 acts as 1, hold stretches L2 to 7 cycles
        layer_cycles = 32'h02040003;
        start = 1'b1; cyc(); start = 1'b0;
        seq("zl1", 5, 128'h42111);
        hold = 1'b1;
        chk("hold_idx", {30'd0, layer_idx}, 32'd2);
        seq("hold", 3, 128'h444);
        hold = 1'b0;
        seq("hold_post", 5, 128'h88444);
        end_chk("hold_end", 8'd1);

        // Loop three passes, start while busy ignored
        layer_cycles = 32'h01010101;
        loop_en = 1'b1;
        start = 1'b1; cyc();
        seq("loop12", 8, 128'h84218421);
        start = 1'b0;
        chk("loop_pass2", {24'd0, pass_cnt}, 32'd2);
        loop_en = 1'b0;
        seq("loop3", 4, 128'h8421);
        end_chk("loop_end", 8'd3);
        cyc();

        // Abort mid-L2
        layer_cycles = 32'h02040102;
        start = 1'b1; cyc(); start = 1'b0;
        seq("ab_pre", 5, 128'h44211);
        abort = 1'b1;
        chk("ab_cyc", {28'd0, layer_en}, 32'h4);
        cyc();
        abort = 1'b0;
        seq("ab_idle", 3, 128'h000);
        chk("ab_pass", {24'd0, pass_cnt}, 32'd0);

        // Restart; mid-run layer_cycles edit ignored; start on done cycle
        start = 1'b1; cyc(); start = 1'b0;
        layer_cycles = 32'h01010101;
        seq("rs", 9, 128'h884444211);
        end_chk("rs_end", 8'd1);
        start = 1'b1; cyc(); start = 1'b0;
        seq("b2b", 4, 128'h8421);
        end_chk("b2b_end", 8'd1);
`else
        // Ack gating: ack[0] late, ack[2] during L0 ignored
        layer_cycles = 32'h01010101;
        layer_ack = 4'b0100;
        start = 1'b1; cyc(); start = 1'b0;
        seq("ack_wait", 5, 128'h11111);
        layer_ack = 4'b0001;
        seq("ack0", 1, 128'h1);
        layer_ack = 4'b1111;
        seq("ack_rest", 6, 128'h884422);
        end_chk("ack_end", 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
